hazard_ctrl: RTL and testbench

- Pipeline hazard and forwarding controller for the 5-stage core (IF, ID, EX, MEM, WB); branch and jump resolution happen in ID.
- Keeps a shadow pipeline of destination tags for the EX, MEM and WB stages.
- Drives the ID-stage forward selects, the registered EX-stage forward selects, stall/bubble/flush controls and a stall-cycle counter.

---
 rtl/hazard_ctrl_pkg.sv | 63 ++++++
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_tag_stage.sv | 21 ++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types, widths and match helpers for the pipeline hazard/forwarding controller.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned FWD_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      stall_cnt_t;

    // Operand source selects: EX = EX/MEM result (instr in MEM), WB = MEM/WB value (instr in WB)
    typedef enum logic [FWD_W-1:0] {
        FWD_NO = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_t;

    // Destination tag carried alongside an instruction through EX, MEM and WB
    typedef struct packed {
        logic      valid;
        logic      reg_write;
        reg_addr_t dst;
        logic      mem_read;
    } stage_tag_t;

    localparam int unsigned TAG_W = $bits(stage_tag_t);

    // A stage produces register r; $0 is hardwired and never matches
    function automatic logic tag_match(stage_tag_t t, reg_addr_t r);
        return t.valid & t.reg_write & (t.dst == r) & (r != '0);
    endfunction

    // A used ID operand must wait: ALU result still in EX for a branch, load in EX,
    // or load in MEM feeding an ID-stage compare
    function automatic logic op_hazard(logic used, reg_addr_t r, stage_tag_t ex,
                                       stage_tag_t mem, logic is_br);
        return used & ((tag_match(ex, r) & (is_br | ex.mem_read)) |
                       (tag_match(mem, r) & mem.mem_read & is_br));
    endfunction

    // ID-stage operand select; the younger MEM producer wins over WB
    function automatic fwd_sel_t id_fwd_sel(logic used, reg_addr_t r, stage_tag_t mem,
                                            stage_tag_t wb);
        if (used & tag_match(mem, r) & ~mem.mem_read) begin
            return FWD_EX;
        end else if (used & tag_match(wb, r)) begin
            return FWD_WB;
        end
        return FWD_NO;
    endfunction

    // Select the operand will need once it sits in EX (producers shift down one stage)
    function automatic fwd_sel_t ex_fwd_sel(logic used, reg_addr_t r, stage_tag_t ex,
                                            stage_tag_t mem);
        if (used & tag_match(ex, r) & ~ex.mem_read) begin
            return FWD_EX;
        end else if (used & tag_match(mem, r) & mem.mem_read) begin
            return FWD_WB;
        end
        return FWD_NO;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode info in, pipeline stall/flush/forward controls out.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic       ext_stall;
    logic       id_valid;
    reg_addr_t  id_rs_addr;
    reg_addr_t  id_rt_addr;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_br;
    logic       id_taken;
    logic       id_reg_write;
    reg_addr_t  id_dst_addr;
    logic       id_mem_read;

    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_bubble;
    fwd_sel_t   fwd_a;
    fwd_sel_t   fwd_b;
    fwd_sel_t   ex_fwd_a;
    fwd_sel_t   ex_fwd_b;
    stall_cnt_t stall_cnt;

    modport master (
        output ext_stall, id_valid, id_rs_addr, id_rt_addr, id_use_rs, id_use_rt,
               id_is_br, id_taken, id_reg_write, id_dst_addr, id_mem_read,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               ex_fwd_a, ex_fwd_b, stall_cnt
    );

    modport slave (
        input  ext_stall, id_valid, id_rs_addr, id_rt_addr, id_use_rs, id_use_rt,
               id_is_br, id_taken, id_reg_write, id_dst_addr, id_mem_read,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               ex_fwd_a, ex_fwd_b, stall_cnt
    );

endinterface

// File: rtl/hazard_tag_stage.sv
// One shadow-pipeline tag register: clear on reset, load when advancing, else hold.
module hazard_tag_stage
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  stage_tag_t d,
    output stage_tag_t q
);

    // Tag register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (advance) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and operand-forwarding control for the 5-stage core (branches resolve in ID).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;
    stage_tag_t id_entry;
    stage_tag_t ex_d;

    logic       use_a;
    logic       use_b;
    logic       haz;
    logic       id_advance;
    logic       pipe_move;

    fwd_sel_t   ex_fwd_a_q;
    fwd_sel_t   ex_fwd_b_q;
    stall_cnt_t stall_cnt_q;

    // Operand qualification, hazard detection and the tag entering EX
    always_comb begin
        use_a      = bus.id_valid & bus.id_use_rs;
        use_b      = bus.id_valid & bus.id_use_rt;
        haz        = op_hazard(use_a, bus.id_rs_addr, ex_tag, mem_tag, bus.id_is_br) |
                     op_hazard(use_b, bus.id_rt_addr, ex_tag, mem_tag, bus.id_is_br);
        pipe_move  = ~bus.ext_stall;
        id_advance = ~haz & ~bus.ext_stall;

        id_entry           = '0;
        id_entry.valid     = bus.id_valid;
        id_entry.reg_write = bus.id_reg_write;
        id_entry.dst       = bus.id_dst_addr;
        id_entry.mem_read  = bus.id_mem_read;

        ex_d = id_advance ? id_entry : stage_tag_t'('0);
    end

    hazard_tag_stage u_ex_tag (
        .clk     (clk),
        .reset   (reset),
        .advance (pipe_move),
        .d       (ex_d),
        .q       (ex_tag)
    );

    hazard_tag_stage u_mem_tag (
        .clk     (clk),
        .reset   (reset),
        .advance (pipe_move),
        .d       (ex_tag),
        .q       (mem_tag)
    );

    hazard_tag_stage u_wb_tag (
        .clk     (clk),
        .reset   (reset),
        .advance (pipe_move),
        .d       (mem_tag),
        .q       (wb_tag)
    );

    // EX forward selects follow the instruction into EX; a bubble carries no forwarding
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_fwd_a_q <= FWD_NO;
            ex_fwd_b_q <= FWD_NO;
        end else if (pipe_move) begin
            if (id_advance) begin
                ex_fwd_a_q <= ex_fwd_sel(use_a, bus.id_rs_addr, ex_tag, mem_tag);
                ex_fwd_b_q <= ex_fwd_sel(use_b, bus.id_rt_addr, ex_tag, mem_tag);
            end else begin
                ex_fwd_a_q <= FWD_NO;
                ex_fwd_b_q <= FWD_NO;
            end
        end
    end

    // Count inserted bubbles; wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (bus.id_ex_bubble) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline controls; a branch waiting on operands never redirects
    assign bus.pc_stall     = haz | bus.ext_stall;
    assign bus.if_id_stall  = haz | bus.ext_stall;
    assign bus.id_ex_bubble = haz & ~bus.ext_stall;
    assign bus.if_id_flush  = bus.id_taken & ~haz & ~bus.ext_stall;
    assign bus.fwd_a        = id_fwd_sel(use_a, bus.id_rs_addr, mem_tag, wb_tag);
    assign bus.fwd_b        = id_fwd_sel(use_b, bus.id_rt_addr, mem_tag, wb_tag);
    assign bus.ex_fwd_a     = ex_fwd_a_q;
    assign bus.ex_fwd_b     = ex_fwd_b_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed per-cycle vectors for hazard_ctrl: inputs for one cycle plus the outputs expected in it.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       tk;
        logic       rw;
        logic [4:0] dst;
        logic       mr;
    } id_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        ext;
        id_t         id;
        logic        stl;
        logic        flu;
        logic        bub;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  efa;
        logic [1:0]  efb;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic id_t ins(logic vld, logic [4:0] rs, logic [4:0] rt, logic urs,
                                logic urt, logic br, logic tk, logic rw, logic [4:0] dst,
                                logic mr);
        id_t i;
        i.vld = vld; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
        i.br = br; i.tk = tk; i.rw = rw; i.dst = dst; i.mr = mr;
        return i;
    endfunction

    function automatic vec_t mk(string name, logic rst, logic ext, id_t id, logic stl,
                                logic flu, logic bub, logic [1:0] fa, logic [1:0] fb,
                                logic [1:0] efa, logic [1:0] efb, logic [31:0] cnt);
        vec_t v;
        v.name = name; v.rst = rst; v.ext = ext; v.id = id;
        v.stl = stl; v.flu = flu; v.bub = bub;
        v.fa = fa; v.fb = fb; v.efa = efa; v.efb = efb; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(logic rst, logic ext, id_t id);
        reset            = rst;
        bus.ext_stall    = ext;
        bus.id_valid     = id.vld;
        bus.id_rs_addr   = id.rs;
        bus.id_rt_addr   = id.rt;
        bus.id_use_rs    = id.urs;
        bus.id_use_rt    = id.urt;
        bus.id_is_br     = id.br;
        bus.id_taken     = id.tk;
        bus.id_reg_write = id.rw;
        bus.id_dst_addr  = id.dst;
        bus.id_mem_read  = id.mr;
    endtask

    // Drive one cycle, compare mid-cycle, then let the edge happen
    task automatic run_vec(vec_t v);
        logic [43:0] got;
        logic [43:0] want;
        drive(v.rst, v.ext, v.id);
        @(negedge clk);
        got  = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_bubble,
                2'(bus.fwd_a), 2'(bus.fwd_b), 2'(bus.ex_fwd_a), 2'(bus.ex_fwd_b),
                32'(bus.stall_cnt)};
        want = {v.stl, v.stl, v.flu, v.bub, v.fa, v.fb, v.efa, v.efb, v.cnt};
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got stall/ifid/flush/bub=%b%b%b%b fwd=%0d/%0d exfwd=%0d/%0d cnt=%0d, want %b%b%b%b fwd=%0d/%0d exfwd=%0d/%0d cnt=%0d",
                     v.name, got[43], got[42], got[41], got[40], got[39:38], got[37:36],
                     got[35:34], got[33:32], got[31:0], want[43], want[42], want[41],
                     want[40], want[39:38], want[37:36], want[35:34], want[33:32],
                     want[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        id_t nop, nop_tk;
        id_t add3, add4, lw5, add6, lw7, beq7, addi8, beq8, lw9, add10;
        id_t lw11, add12, wr0, beq00, add14, add15, add16;

        nop    = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop_tk = ins(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add3   = ins(1, 1, 2, 1, 1, 0, 0, 1, 3, 0);
        add4   = ins(1, 3, 3, 1, 1, 0, 0, 1, 4, 0);
        lw5    = ins(1, 1, 5, 1, 0, 0, 0, 1, 5, 1);
        add6   = ins(1, 5, 0, 1, 1, 0, 0, 1, 6, 0);
        lw7    = ins(1, 1, 7, 1, 0, 0, 0, 1, 7, 1);
        beq7   = ins(1, 7, 0, 1, 1, 1, 1, 0, 0, 0);
        addi8  = ins(1, 0, 8, 1, 0, 0, 0, 1, 8, 0);
        beq8   = ins(1, 8, 0, 1, 1, 1, 0, 0, 0, 0);
        lw9    = ins(1, 1, 9, 1, 0, 0, 0, 1, 9, 1);
        add10  = ins(1, 9, 9, 1, 1, 0, 0, 1, 10, 0);
        lw11   = ins(1, 1, 11, 1, 0, 0, 0, 1, 11, 1);
        add12  = ins(1, 11, 0, 1, 1, 0, 0, 1, 12, 0);
        wr0    = ins(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        beq00  = ins(1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        add14  = ins(1, 1, 2, 1, 1, 0, 0, 1, 14, 0);
        add15  = ins(1, 14, 14, 1, 1, 0, 0, 1, 15, 0);
        add16  = ins(1, 14, 0, 1, 1, 0, 0, 1, 16, 0);

        //              name        rst ext id      stl flu bub fa fb efa efb cnt
        vecs.push_back(mk("A0_add3",  0, 0, add3,   0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("A1_add4",  0, 0, add4,   0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("A2_exfwd", 0, 0, nop,    0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("B0_lw5",   0, 0, lw5,    0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("B1_use",   0, 0, add6,   1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("B2_go",    0, 0, add6,   0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("B3_exwb",  0, 0, nop,    0, 0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk("C0_lw7",   0, 0, lw7,    0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("C1_st1",   0, 0, beq7,   1, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("C2_st2",   0, 0, beq7,   1, 0, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk("C3_take",  0, 0, beq7,   0, 1, 0, 2, 0, 0, 0, 3));
        vecs.push_back(mk("C4_nop",   0, 0, nop,    0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("D0_addi8", 0, 0, addi8,  0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("D1_nop",   0, 0, nop,    0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("D2_beq8",  0, 0, beq8,   0, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk("D3_nop",   0, 0, nop,    0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("E0_lw9",   0, 0, lw9,    0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("E1_ext",   0, 1, add10,  1, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("E2_ext",   0, 1, add10,  1, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("E3_ext",   0, 1, add10,  1, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk("E4_resume",0, 0, add10,  1, 0, 1, 0, 0, 0, 0, 3));
        vecs.push_back(mk("E5_go",    0, 0, add10,  0, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk("E6_exwb",  0, 0, nop,    0, 0, 0, 0, 0, 2, 2, 4));
        vecs.push_back(mk("E7_extflu",0, 1, nop_tk, 1, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk("F0_lw11",  0, 0, lw11,   0, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk("F1_rststl",1, 0, add12,  1, 0, 1, 0, 0, 0, 0, 4));
        vecs.push_back(mk("F2_cleared",0,0, add12,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("F3_wr0",   0, 0, wr0,    0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("F4_rd0_ex",0, 0, beq00,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("F5_rd0_mem",0,0, beq00,  0, 1, 0, 0, 0, 0, 0, 0));

        // Reset state: two reset edges, then check with a would-be hazard and taken on the inputs
        drive(1, 0, nop);
        repeat (2) @(posedge clk);
        #1;
        run_vec(mk("reset_state", 1, 0, ins(1, 5, 5, 1, 1, 1, 1, 1, 5, 1),
                   0, 1, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // ext_stall holds a nonzero EX forward select and the MEM producer
        run_vec(mk("G0_add14",    0, 0, add14, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk("G1_add15",    0, 0, add15, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk("G2_hold",     0, 1, nop,   1, 0, 0, 0, 0, 1, 1, 0));
        run_vec(mk("G3_hold",     0, 1, nop,   1, 0, 0, 0, 0, 1, 1, 0));
        run_vec(mk("G4_memfwd",   0, 0, add16, 0, 0, 0, 1, 0, 1, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
